// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: handshake-stage state and the per-stage
// bundle widths used when instantiating pipe_stage_reg between stages.
package pipe_pkg;

    // State doubles as occupancy: encoding value == entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    // Inter-stage bundle widths (payload bits, control field on top).
    localparam int IFID_W       = 64;
    localparam int IDEX_W       = 147;
    localparam int EXMEM_W      = 75;
    localparam int EXMEM_CTRL_W = 6;
    localparam int MEMWB_W      = 71;
    localparam int MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, synchronous
// flush that squashes control bits, and an optional two-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH  = EXMEM_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Ones over the top CTRL_W bits; all-zero for CTRL_W=0, all-one for
    // CTRL_W=WIDTH (the shift runs out of bits).
    localparam logic [WIDTH-1:0] CTRL_MASK = ~({WIDTH{1'b1}} >> CTRL_W);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Control field reads as zero whenever nothing valid is presented.
    assign out_data  = out_valid ? m_q : (m_q & ~CTRL_MASK);

    // Skid variant: ready comes from flops only, so out_ready never reaches
    // in_ready combinationally. Plain variant: accept when M frees this cycle.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != ST_TWO);
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and storage update; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            // An accepted input beat is simply dropped here.
            state_d = ST_EMPTY;
            m_d     = m_q & ~CTRL_MASK;
            s_d     = s_q & ~CTRL_MASK;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        m_d     = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_d = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        // Downstream stalled: park the new beat behind M.
                        state_d = ST_TWO;
                        s_d     = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        m_d     = s_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and payload registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one plain instance, each
// shadowed by a queue model, plus directed vectors with literal expectations.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W  = 75;
    localparam int CW = 6;
    localparam logic [W-1:0] CM = {{CW{1'b1}}, {(W-CW){1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         fl1 = 0, iv1 = 0, or1 = 0, ir1, ov1;
    logic [W-1:0] id1 = '0, od1;
    logic [1:0]   oc1;
    logic         fl0 = 0, iv0 = 0, or0 = 0, ir0, ov0;
    logic [W-1:0] id0 = '0, od0;
    logic [1:0]   oc0;

    pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1));

    pipe_stage_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(0)) u_plain (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(oc0));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a FIFO of accepted beats, capacity 2 (skid) or 1.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit mi1, mo1, mi0, mo0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            mo1 = (q1.size() != 0) && or1;
            mi1 = iv1 && (q1.size() < 2);
            if (fl1) q1.delete();
            else begin
                if (mo1) void'(q1.pop_front());
                if (mi1) q1.push_back(id1);
            end
            mo0 = (q0.size() != 0) && or0;
            mi0 = iv0 && ((q0.size() == 0) || or0);
            if (fl0) q0.delete();
            else begin
                if (mo0) void'(q0.pop_front());
                if (mi0) q0.push_back(id0);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m1_in_ready", W'(ir1), W'(q1.size() < 2));
        chk("m1_out_valid", W'(ov1), W'(q1.size() != 0));
        chk("m1_occupancy", W'(oc1), W'(q1.size()));
        if (q1.size() != 0) chk("m1_out_data", od1, q1[0]);
        else                chk("m1_ctrl_zero", od1 & CM, '0);
        chk("m0_in_ready", W'(ir0), W'((q0.size() == 0) || or0));
        chk("m0_out_valid", W'(ov0), W'(q0.size() != 0));
        chk("m0_occupancy", W'(oc0), W'(q0.size()));
        if (q0.size() != 0) chk("m0_out_data", od0, q0[0]);
        else                chk("m0_ctrl_zero", od0 & CM, '0);
    end

    logic [W-1:0] A, B, C, D, G, H, J;
    logic [95:0]  r;

    initial begin
        A = {6'h01, 69'hA};
        B = {6'h02, 69'hB};
        C = {6'h03, 69'hC};
        D = {6'h3F, 69'hD};
        G = {6'h15, 69'h1234};
        H = {6'h21, 69'h77};
        J = {6'h22, 69'h88};

        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", W'(ov1), W'(0));
        chk("rst_out_data", od1, '0);
        chk("rst_occupancy", W'(oc1), W'(0));
        chk("rst_in_ready", W'(ir1), W'(1));
        chk("rst_in_ready_plain", W'(ir0), W'(1));
        tick();
        rst = 1'b0;

        // Stream: back-to-back beats, never stalled.
        or1 = 1; iv1 = 1;
        for (int i = 1; i <= 8; i++) begin
            id1 = W'(i);
            tick();
            chk("stream_data", od1, W'(i));
            chk("stream_occ", W'(oc1), W'(1));
            chk("stream_ready", W'(ir1), W'(1));
        end
        iv1 = 0;
        tick();
        chk("stream_drain", W'(oc1), W'(0));

        // Backpressure: A in M, B in S, C held upstream.
        or1 = 0; iv1 = 1; id1 = A;
        tick();
        id1 = B;
        tick();
        id1 = C;
        tick();
        chk("bp_head", od1, A);
        chk("bp_occ", W'(oc1), W'(2));
        chk("bp_ready", W'(ir1), W'(0));
        or1 = 1;
        tick();
        chk("bp_second", od1, B);
        tick();
        chk("bp_third", od1, C);
        iv1 = 0;
        tick();
        chk("bp_empty", W'(ov1), W'(0));

        // Flush while holding two control-heavy beats; D offered alongside.
        or1 = 0; iv1 = 1; id1 = {6'h3F, 69'h111};
        tick();
        id1 = {6'h3F, 69'h222};
        tick();
        chk("fl_occ2", W'(oc1), W'(2));
        fl1 = 1; id1 = D;
        tick();
        fl1 = 0; iv1 = 0;
        chk("fl_valid", W'(ov1), W'(0));
        chk("fl_ctrl", od1 & CM, '0);
        chk("fl_occ", W'(oc1), W'(0));
        chk("fl_ready", W'(ir1), W'(1));
        or1 = 1;
        tick();
        chk("fl_no_d", W'(ov1), W'(0));

        // Flush in ONE with a same-cycle accepted beat: both squashed.
        or1 = 0; iv1 = 1; id1 = A;
        tick();
        fl1 = 1; id1 = B;
        tick();
        fl1 = 0; iv1 = 0;
        chk("fl1_valid", W'(ov1), W'(0));
        tick();
        chk("fl1_no_b", W'(ov1), W'(0));

        // Asynchronous reset in the middle of a full stall.
        or1 = 0; iv1 = 1; id1 = A;
        tick();
        id1 = B;
        tick();
        iv1 = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", W'(ov1), W'(0));
        chk("arst_data", od1, '0);
        chk("arst_ready", W'(ir1), W'(1));
        chk("arst_occ", W'(oc1), W'(0));
        tick();
        rst = 1'b0;
        iv1 = 1; id1 = G; or1 = 1;
        tick();
        iv1 = 0;
        chk("arst_first", od1, G);
        chk("arst_first_v", W'(ov1), W'(1));
        tick();

        // Plain register: in_ready follows out_ready while full.
        or0 = 0; iv0 = 1; id0 = H;
        tick();
        chk("plain_hold", od0, H);
        chk("plain_stall_ready", W'(ir0), W'(0));
        or0 = 1; id0 = J;
        #1;
        chk("plain_pass_ready", W'(ir0), W'(1));
        tick();
        chk("plain_replace", od0, J);
        iv0 = 0;
        tick();
        chk("plain_empty", W'(ov0), W'(0));

        // Random traffic on both instances; the model checks every cycle.
        for (int n = 0; n < 10000; n++) begin
            r   = {$urandom, $urandom, $urandom};
            id1 = r[W-1:0];
            r   = {$urandom, $urandom, $urandom};
            id0 = r[W-1:0];
            iv1 = ($urandom_range(0, 3) != 0);
            iv0 = ($urandom_range(0, 3) != 0);
            or1 = ($urandom_range(0, 2) != 0);
            or0 = ($urandom_range(0, 2) != 0);
            fl1 = ($urandom_range(0, 63) == 0);
            fl0 = ($urandom_range(0, 63) == 0);
            tick();
        end
        iv1 = 0; iv0 = 0; fl1 = 0; fl0 = 0; or1 = 1; or0 = 1;
        tick();
        tick();
        tick();
        chk("final_drain1", W'(oc1), W'(0));
        chk("final_drain0", W'(oc0), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
